mcu_pwm_multi: RTL



---
 rtl/mcu_pwm_multi_if.sv | 18 +
 rtl/mcu_pwm_multi.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mcu_pwm_multi_if.sv
// ----------------------------------------------------------------------------
// mcu_pwm_multi_if
// SAM MCU static-memory bus as seen by the PWM block.
//   pwm_ncs        chip select, active-low (asynchronous to pwm_clk)
//   pwm_nwe        write enable, active-low
//   pwm_addr       byte address
//   pwm_sram_data  write data
// master: MCU side (drives everything); slave: PWM block (samples everything).
// ----------------------------------------------------------------------------
interface mcu_pwm_multi_if;
    logic       pwm_ncs;
    logic       pwm_nwe;
    logic [7:0] pwm_addr;
    logic [7:0] pwm_sram_data;

    modport master (output pwm_ncs, output pwm_nwe, output pwm_addr, output pwm_sram_data);
    modport slave  (input  pwm_ncs, input  pwm_nwe, input  pwm_addr, input  pwm_sram_data);
endinterface

// File: rtl/mcu_pwm_multi.sv
// ----------------------------------------------------------------------------
// mcu_pwm_multi
// Multi-channel PWM generator programmed over the MCU static-memory bus.
// NUM_CH channels share one CNT_WIDTH-bit period counter. Registers are
// written a byte lane at a time (reg = addr[7:2], lane = addr[1:0]):
//   reg 0     CTRL  lane 0: bit0 ENABLE, bit1 COMMIT (self-clearing)
//   reg 1     PERIOD
//   reg 2+n   DUTY[n]
// Build option MCU_PWM_SHADOW_EN:
//   defined   PERIOD/DUTY land in shadow registers; COMMIT arms a transfer
//             to the active set on the next period boundary (all channels
//             atomically, so no runt pulses).
//   undefined PERIOD/DUTY are written straight into the active registers;
//             COMMIT has no effect.
// Ports:
//   pwm_clk          single clock (bus capture and PWM)
//   reset            synchronous, active-high
//   bus              mcu_pwm_multi_if.slave (ncs, nwe, addr, data)
//   pwm_out          PWM outputs, bit n = channel n (registered)
//   pwm_period_tick  one-cycle pulse per period boundary (registered)
// ----------------------------------------------------------------------------
module mcu_pwm_multi #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 24
) (
    input  logic                 pwm_clk,
    input  logic                 reset,
    mcu_pwm_multi_if.slave       bus,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic                 pwm_period_tick
);
    localparam int LANES = CNT_WIDTH / 8;

    typedef logic [CNT_WIDTH-1:0] word_t;
    localparam word_t ONE = word_t'(1);

    // Replace one byte lane of a register value.
    function automatic word_t put_byte(input word_t v, input logic [1:0] ln,
                                       input logic [7:0] b);
        word_t r;
        r = v;
        for (int i = 0; i < LANES; i++) begin
            if (int'(ln) == i) r[i*8 +: 8] = b;
        end
        return r;
    endfunction

    // ---------------- bus capture ----------------
    logic       ncs1_q, nwe1_q, ncs2_q, nwe2_q;
    logic [7:0] addr1_q, data1_q;
    // s1_vld_q: stage 1 holds a real bus sample (not just its reset value).
    // armed_q : stage 1 has seen the bus inactive since reset, so an access
    //           that straddled reset cannot produce a strobe afterwards.
    logic       s1_vld_q, armed_q;
    logic       act1, act2, we;

    always_ff @(posedge pwm_clk) begin
        if (reset) begin
            ncs1_q   <= 1'b1;
            nwe1_q   <= 1'b1;
            ncs2_q   <= 1'b1;
            nwe2_q   <= 1'b1;
            addr1_q  <= '0;
            data1_q  <= '0;
            s1_vld_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            ncs1_q   <= bus.pwm_ncs;
            nwe1_q   <= bus.pwm_nwe;
            addr1_q  <= bus.pwm_addr;
            data1_q  <= bus.pwm_sram_data;
            ncs2_q   <= ncs1_q;
            nwe2_q   <= nwe1_q;
            s1_vld_q <= 1'b1;
            armed_q  <= armed_q | (s1_vld_q & ~act1);
        end
    end

    assign act1 = ~(ncs1_q | nwe1_q);
    assign act2 = ~(ncs2_q | nwe2_q);
    // Rising edge of "active": one strobe per access regardless of length.
    assign we   = act1 & ~act2 & armed_q;

    // ---------------- decode ----------------
    logic [5:0]        idx;
    logic [1:0]        lane;
    logic              lane_ok, wr_ctrl, wr_per;
    logic [NUM_CH-1:0] wr_duty;

    assign idx     = addr1_q[7:2];
    assign lane    = addr1_q[1:0];
    assign lane_ok = (int'(lane) < LANES);
    assign wr_ctrl = we & (idx == 6'd0) & (lane == 2'd0);
    assign wr_per  = we & lane_ok & (idx == 6'd1);

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            wr_duty[n] = we & lane_ok & (int'(idx) == n + 2);
        end
    end

    // ---------------- state ----------------
    logic                            en_q, en_d;
    word_t                           cnt_q, cnt_d;
    word_t                           per_a_q, per_a_d;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] duty_a_q, duty_a_d;
    logic [NUM_CH-1:0]               out_d;
    logic                            tick_d;
    logic                            run, bnd;

`ifdef MCU_PWM_SHADOW_EN
    logic                            pend_q, pend_d, commit;
    word_t                           per_s_q, per_s_d;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] duty_s_q, duty_s_d;
`endif

    always_comb begin
        run = en_q & (per_a_q != '0);
        // Stopped counter: every cycle is a boundary so a commit lands at once.
        bnd = ~run | (cnt_q == per_a_q - ONE);
        cnt_d = bnd ? '0 : cnt_q + ONE;
        en_d  = wr_ctrl ? data1_q[0] : en_q;
`ifdef MCU_PWM_SHADOW_EN
        commit   = bnd & pend_q;
        // A COMMIT write wins over the clear of a transfer in the same edge.
        pend_d   = (wr_ctrl & data1_q[1]) | (pend_q & ~commit);
        per_s_d  = wr_per ? put_byte(per_s_q, lane, data1_q) : per_s_q;
        per_a_d  = commit ? per_s_q : per_a_q;
        duty_s_d = duty_s_q;
        duty_a_d = commit ? duty_s_q : duty_a_q;
        for (int n = 0; n < NUM_CH; n++) begin
            if (wr_duty[n]) duty_s_d[n] = put_byte(duty_s_q[n], lane, data1_q);
        end
`else
        per_a_d  = wr_per ? put_byte(per_a_q, lane, data1_q) : per_a_q;
        duty_a_d = duty_a_q;
        for (int n = 0; n < NUM_CH; n++) begin
            if (wr_duty[n]) duty_a_d[n] = put_byte(duty_a_q[n], lane, data1_q);
        end
`endif
        for (int n = 0; n < NUM_CH; n++) begin
            out_d[n] = run & (cnt_q < duty_a_q[n]);
        end
        tick_d = bnd & run;
    end

    always_ff @(posedge pwm_clk) begin
        if (reset) begin
            en_q            <= 1'b0;
            cnt_q           <= '0;
            per_a_q         <= '0;
            duty_a_q        <= '0;
            pwm_out         <= '0;
            pwm_period_tick <= 1'b0;
`ifdef MCU_PWM_SHADOW_EN
            pend_q          <= 1'b0;
            per_s_q         <= '0;
            duty_s_q        <= '0;
`endif
        end else begin
            en_q            <= en_d;
            cnt_q           <= cnt_d;
            per_a_q         <= per_a_d;
            duty_a_q        <= duty_a_d;
            pwm_out         <= out_d;
            pwm_period_tick <= tick_d;
`ifdef MCU_PWM_SHADOW_EN
            pend_q          <= pend_d;
            per_s_q         <= per_s_d;
            duty_s_q        <= duty_s_d;
`endif
        end
    end
endmodule
